rgmii_tx_rate_gen: RTL and testbench

//  Multi-rate RGMII transmit launcher. Feeds the external DDR output cells from the GMII TX side.

---
 rtl/rgmii_tx_rate_gen_pkg.sv | 17 +
 rtl/rgmii_tx_rate_gen_if.sv | 10 +
 rtl/rgmii_tx_rate_gen_clk_div.sv | 46 ++++
 rtl/rgmii_tx_rate_gen.sv | 187 ++++++++++++++++++
 tb/tb_rgmii_tx_rate_gen.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_tx_rate_gen_pkg.sv
// Shared encodings for the multi-rate RGMII transmit launcher.
package rgmii_tx_rate_gen_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  localparam logic [1:0] ST_RUN       = 2'b00;
  localparam logic [1:0] ST_WAIT_IDLE = 2'b01;
  localparam logic [1:0] ST_GUARD     = 2'b10;

  // The unused 2'b11 request code is treated as gigabit.
  function automatic logic [1:0] norm_speed(input logic [1:0] req);
    return (req == 2'b11) ? SPEED_1G : req;
  endfunction

endpackage

// File: rtl/rgmii_tx_rate_gen_if.sv
// GMII transmit side between the MAC and the RGMII launcher.
interface rgmii_tx_rate_gen_if;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       tx_clk_en;

  modport master (output txd, tx_en, tx_er, input tx_clk_en);
  modport slave  (input txd, tx_en, tx_er, output tx_clk_en);
endinterface

// File: rtl/rgmii_tx_rate_gen_clk_div.sv
// 10/100 divider: period counter, period-end strobe and TXC half-cycle phases.
// Phases are derived from the next count so the output registers line up
// with the counter value they represent.
module rgmii_tx_rate_gen_clk_div #(
  parameter int DIV_100M  = 5,
  parameter int DIV_10M   = 50,
  parameter int CNT_WIDTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_100m,
  input  logic clear,
  output logic period_end,
  output logic ph1,
  output logic ph2
);

  localparam logic [CNT_WIDTH-1:0] LAST_100 = CNT_WIDTH'(DIV_100M - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_10  = CNT_WIDTH'(DIV_10M - 1);
  localparam logic [CNT_WIDTH-1:0] HALF_100 = CNT_WIDTH'(DIV_100M / 2);
  localparam logic [CNT_WIDTH-1:0] HALF_10  = CNT_WIDTH'(DIV_10M / 2);
  localparam logic ODD_100 = (DIV_100M % 2) == 1;
  localparam logic ODD_10  = (DIV_10M % 2) == 1;

  logic [CNT_WIDTH-1:0] count, count_nxt, last, half;
  logic odd;

  // Wrap on >= last so a stray out-of-range count recovers in one cycle;
  // odd divisors rise mid-cycle (d2 leads d1) for an exact 50% duty.
  always_comb begin
    last       = sel_100m ? LAST_100 : LAST_10;
    half       = sel_100m ? HALF_100 : HALF_10;
    odd        = sel_100m ? ODD_100 : ODD_10;
    period_end = (count >= last);
    count_nxt  = (clear || period_end) ? '0 : count + CNT_WIDTH'(1);
    ph2        = (count_nxt >= half);
    ph1        = odd ? (count_nxt > half) : ph2;
  end

  // Period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/rgmii_tx_rate_gen.sv
// Multi-rate RGMII transmit launcher: produces registered d1/d2 words for the
// TXC, TD and TX_CTL output DDR cells and the MAC clock enable. Speed changes
// wait for an idle frame boundary and then insert a quiet guard gap.
module rgmii_tx_rate_gen
  import rgmii_tx_rate_gen_pkg::*;
#(
  parameter int DIV_100M     = 5,
  parameter int DIV_10M      = 50,
  parameter int GUARD_CYCLES = 8,
  parameter int CNT_WIDTH    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         speed_req,
  rgmii_tx_rate_gen_if.slave gmii,
  output logic               txc_d1,
  output logic               txc_d2,
  output logic [3:0]         txd_d1,
  output logic [3:0]         txd_d2,
  output logic               tx_ctl_d1,
  output logic               tx_ctl_d2,
  output logic [1:0]         speed_active,
  output logic               switch_busy
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  logic [1:0]    state, state_nxt, target, target_nxt, speed_nxt, req;
  logic          busy_nxt;
  logic [GW-1:0] guard_cnt;
  logic [3:0]    hold_txd, hold_txd_nxt;
  logic          hold_en, hold_er, hold_en_nxt, hold_er_nxt;
  logic          is_1g, in_guard, tick, period_end, ph1, ph2, clk_en;
  logic          txc1_nxt, txc2_nxt, ctl1_nxt, ctl2_nxt;
  logic [3:0]    td1_nxt, td2_nxt;

  assign req      = norm_speed(speed_req);
  assign is_1g    = (speed_active == SPEED_1G);
  assign in_guard = (state == ST_GUARD);
  assign tick     = is_1g | period_end;
  assign clk_en   = tick & ~in_guard;
  assign gmii.tx_clk_en = clk_en;

  rgmii_tx_rate_gen_clk_div #(
    .DIV_100M  (DIV_100M),
    .DIV_10M   (DIV_10M),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_clk_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_100m   (speed_active == SPEED_100M),
    .clear      (is_1g | in_guard),
    .period_end (period_end),
    .ph1        (ph1),
    .ph2        (ph2)
  );

  // Speed-change sequencing; a frame in flight is never cut short.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    speed_nxt  = speed_active;
    busy_nxt   = switch_busy;
    case (state)
      ST_RUN: begin
        if (req != speed_active) begin
          state_nxt  = ST_WAIT_IDLE;
          target_nxt = req;
          busy_nxt   = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (req == speed_active) begin
          state_nxt = ST_RUN;
          busy_nxt  = 1'b0;
        end else begin
          target_nxt = req;
          if (tick && !gmii.tx_en && !hold_en) state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = ST_RUN;
          speed_nxt = target;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Hold registers: MAC sample taken on each enable, flushed during the gap.
  always_comb begin
    hold_txd_nxt = hold_txd;
    hold_en_nxt  = hold_en;
    hold_er_nxt  = hold_er;
    if (in_guard) begin
      hold_txd_nxt = '0;
      hold_en_nxt  = 1'b0;
      hold_er_nxt  = 1'b0;
    end else if (clk_en) begin
      hold_txd_nxt = gmii.txd[3:0];
      hold_en_nxt  = gmii.tx_en;
      hold_er_nxt  = gmii.tx_er;
    end
  end

  // Next ODDR words: quiet during the gap, direct nibbles at 1G, held nibble
  // with a divided TXC at 10/100 (TX_CTL carries en in the high half, en^er in the low).
  always_comb begin
    txc1_nxt = 1'b0;
    txc2_nxt = 1'b0;
    td1_nxt  = '0;
    td2_nxt  = '0;
    ctl1_nxt = 1'b0;
    ctl2_nxt = 1'b0;
    if (state_nxt != ST_GUARD) begin
      if (speed_nxt == SPEED_1G) begin
        txc1_nxt = 1'b1;
        if (clk_en) begin
          td1_nxt  = gmii.txd[3:0];
          td2_nxt  = gmii.txd[7:4];
          ctl1_nxt = gmii.tx_en;
          ctl2_nxt = gmii.tx_en ^ gmii.tx_er;
        end
      end else begin
        txc1_nxt = ph1;
        txc2_nxt = ph2;
        td1_nxt  = hold_txd_nxt;
        td2_nxt  = hold_txd_nxt;
        ctl1_nxt = ph1 ? hold_en_nxt : (hold_en_nxt ^ hold_er_nxt);
        ctl2_nxt = ph2 ? hold_en_nxt : (hold_en_nxt ^ hold_er_nxt);
      end
    end
  end

  // Control state: FSM, target, active speed, busy flag and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      target       <= SPEED_1G;
      speed_active <= SPEED_1G;
      switch_busy  <= 1'b0;
      guard_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      speed_active <= speed_nxt;
      switch_busy  <= busy_nxt;
      guard_cnt    <= in_guard ? guard_cnt + GW'(1) : '0;
    end
  end

  // Hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_txd <= '0;
      hold_en  <= 1'b0;
      hold_er  <= 1'b0;
    end else begin
      hold_txd <= hold_txd_nxt;
      hold_en  <= hold_en_nxt;
      hold_er  <= hold_er_nxt;
    end
  end

  // Output registers feeding the DDR cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txc_d1    <= 1'b1;
      txc_d2    <= 1'b0;
      txd_d1    <= '0;
      txd_d2    <= '0;
      tx_ctl_d1 <= 1'b0;
      tx_ctl_d2 <= 1'b0;
    end else begin
      txc_d1    <= txc1_nxt;
      txc_d2    <= txc2_nxt;
      txd_d1    <= td1_nxt;
      txd_d2    <= td2_nxt;
      tx_ctl_d1 <= ctl1_nxt;
      tx_ctl_d2 <= ctl2_nxt;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_rate_gen.sv
// Bench for rgmii_tx_rate_gen: reference model feeds a per-cycle scoreboard,
// plus a few directed checks around speed changes and reset.
`timescale 1ns/1ps
module tb_rgmii_tx_rate_gen;

  localparam int G = 8;
  localparam int M_RUN = 0, M_WAIT = 1, M_GUARD = 2;

  typedef struct packed {
    logic       txc1;
    logic       txc2;
    logic [3:0] td1;
    logic [3:0] td2;
    logic       c1;
    logic       c2;
    logic       cen;
    logic [1:0] spd;
    logic       busy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] speed_req = 2'b10;
  logic       txc_d1, txc_d2, tx_ctl_d1, tx_ctl_d2, switch_busy;
  logic [3:0] txd_d1, txd_d2;
  logic [1:0] speed_active;

  rgmii_tx_rate_gen_if gmii_bus();

  rgmii_tx_rate_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .speed_req    (speed_req),
    .gmii         (gmii_bus),
    .txc_d1       (txc_d1),
    .txc_d2       (txc_d2),
    .txd_d1       (txd_d1),
    .txd_d2       (txd_d2),
    .tx_ctl_d1    (tx_ctl_d1),
    .tx_ctl_d2    (tx_ctl_d2),
    .speed_active (speed_active),
    .switch_busy  (switch_busy)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference model: what the line should look like in the current cycle.
  int         m_spd, m_mode, m_phase, m_guard, m_target;
  bit         m_busy, m_last_cen;
  logic [3:0] m_htxd;
  bit         m_hen, m_her;
  bit         o_txc1, o_txc2, o_c1, o_c2;
  logic [3:0] o_td1, o_td2;

  function automatic int period_of(input int spd);
    return (spd == 1) ? 5 : 50;
  endfunction

  function automatic int norm(input logic [1:0] s);
    return (s == 2'b11) ? 2 : int'(s);
  endfunction

  task automatic model_reset();
    m_spd = 2; m_mode = M_RUN; m_phase = 0; m_guard = 0; m_target = 2;
    m_busy = 0; m_last_cen = 1;
    m_htxd = '0; m_hen = 0; m_her = 0;
    o_txc1 = 1; o_txc2 = 0; o_c1 = 0; o_c2 = 0; o_td1 = '0; o_td2 = '0;
  endtask

  task automatic model_cycle();
    int n, nn, req, n_mode, n_spd, n_phase;
    bit tick, cen, n_busy;
    n    = period_of(m_spd);
    tick = (m_spd == 2) || (m_phase == n - 1);
    cen  = tick && (m_mode != M_GUARD);
    q.push_back(obs_t'({o_txc1, o_txc2, o_td1, o_td2, o_c1, o_c2, cen, 2'(m_spd), m_busy}));
    m_last_cen = cen;

    req = norm(speed_req);
    n_mode = m_mode; n_spd = m_spd; n_busy = m_busy;
    case (m_mode)
      M_RUN: if (req != m_spd) begin n_mode = M_WAIT; m_target = req; n_busy = 1; end
      M_WAIT: begin
        if (req == m_spd) begin
          n_mode = M_RUN; n_busy = 0;
        end else begin
          m_target = req;
          if (tick && !gmii_bus.tx_en && !m_hen) begin n_mode = M_GUARD; m_guard = G; end
        end
      end
      default: begin
        m_guard--;
        if (m_guard == 0) begin n_mode = M_RUN; n_spd = m_target; n_busy = 0; end
      end
    endcase
    n_phase = (m_mode == M_GUARD || m_spd == 2 || tick) ? 0 : m_phase + 1;

    if (m_mode == M_GUARD) begin
      m_htxd = '0; m_hen = 0; m_her = 0;
    end else if (cen) begin
      m_htxd = gmii_bus.txd[3:0]; m_hen = gmii_bus.tx_en; m_her = gmii_bus.tx_er;
    end

    o_txc1 = 0; o_txc2 = 0; o_c1 = 0; o_c2 = 0; o_td1 = '0; o_td2 = '0;
    if (n_mode != M_GUARD) begin
      if (n_spd == 2) begin
        o_txc1 = 1;
        if (cen) begin
          o_td1 = gmii_bus.txd[3:0]; o_td2 = gmii_bus.txd[7:4];
          o_c1 = gmii_bus.tx_en; o_c2 = gmii_bus.tx_en ^ gmii_bus.tx_er;
        end
      end else begin
        // TXC period spans 2N half-cycles; it is high in the second N of them.
        nn = period_of(n_spd);
        o_txc1 = (2 * n_phase >= nn);
        o_txc2 = (2 * n_phase + 1 >= nn);
        o_td1 = m_htxd; o_td2 = m_htxd;
        o_c1 = o_txc1 ? m_hen : (m_hen ^ m_her);
        o_c2 = o_txc2 ? m_hen : (m_hen ^ m_her);
      end
    end
    m_mode = n_mode; m_spd = n_spd; m_busy = n_busy; m_phase = n_phase;
  endtask

  task automatic step(input logic [1:0] sreq, input logic [7:0] d, input logic e, input logic r);
    speed_req = sreq;
    gmii_bus.txd = d;
    gmii_bus.tx_en = e;
    gmii_bus.tx_er = r;
    model_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic settle(input logic [1:0] sreq, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      if (m_mode == M_RUN && m_spd == norm(sreq)) break;
      step(sreq, 8'($urandom), 1'b0, 1'b0);
    end
    check(name, int'(speed_active), norm(sreq));
  endtask

  // Scoreboard monitor: one full-word comparison per cycle.
  always @(negedge clk) begin
    obs_t exp_o, act_o;
    if (rst_n && q.size() > 0) begin
      exp_o = q.pop_front();
      act_o = {txc_d1, txc_d2, txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2,
               gmii_bus.tx_clk_en, speed_active, switch_busy};
      n_checks++;
      if (act_o === exp_o) n_pass++;
      else $display("FAIL scoreboard cyc %0d: got txc=%b%b td=%h/%h ctl=%b%b cen=%b spd=%b busy=%b, expected txc=%b%b td=%h/%h ctl=%b%b cen=%b spd=%b busy=%b",
                    cyc, act_o.txc1, act_o.txc2, act_o.td1, act_o.td2, act_o.c1, act_o.c2, act_o.cen, act_o.spd, act_o.busy,
                    exp_o.txc1, exp_o.txc2, exp_o.td1, exp_o.td2, exp_o.c1, exp_o.c2, exp_o.cen, exp_o.spd, exp_o.busy);
    end
  end

  initial begin
    int cnt;
    int frame_left;
    logic [1:0] sreq;
    logic e;

    gmii_bus.txd = '0; gmii_bus.tx_en = 1'b0; gmii_bus.tx_er = 1'b0;
    model_reset();
    #12;
    check("reset txc_d1", int'(txc_d1), 1);
    check("reset txc_d2", int'(txc_d2), 0);
    check("reset txd", int'({txd_d1, txd_d2}), 0);
    check("reset ctl", int'({tx_ctl_d1, tx_ctl_d2}), 0);
    check("reset clk_en", int'(gmii_bus.tx_clk_en), 1);
    check("reset speed", int'(speed_active), 2);
    check("reset busy", int'(switch_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1G launch, one-cycle latency.
    step(2'b10, 8'h00, 1'b0, 1'b0);
    step(2'b10, 8'hA5, 1'b1, 1'b0);
    check("1g txd_d1", int'(txd_d1), 'h5);
    check("1g txd_d2", int'(txd_d2), 'hA);
    check("1g ctl", int'({tx_ctl_d1, tx_ctl_d2}), 'b11);
    check("1g txc", int'({txc_d1, txc_d2}), 'b10);
    check("1g clk_en", int'(gmii_bus.tx_clk_en), 1);

    // 1G -> 100M requested mid-frame.
    for (int i = 0; i < 20; i++) begin
      step(i >= 5 ? 2'b01 : 2'b10, 8'($urandom), 1'b1, 1'b0);
      if (i == 10) begin
        check("mid-frame busy", int'(switch_busy), 1);
        check("mid-frame speed kept", int'(speed_active), 2);
      end
    end
    settle(2'b01, 100, "switch to 100M");

    // 100M traffic with en=1, er=1.
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step(2'b01, 8'h3C, 1'b1, 1'b1);
      cnt += int'(gmii_bus.tx_clk_en);
    end
    check("100M clk_en per 25 cycles", cnt, 5);

    // 100M -> 10M during a frame, cancelled back to 100M.
    for (int i = 0; i < 40; i++) begin
      step((i >= 5 && i < 15) ? 2'b00 : 2'b01, 8'($urandom), 1'b1, 1'b0);
      if (i == 10) check("cancel busy set", int'(switch_busy), 1);
      if (i == 20) begin
        check("cancel busy clear", int'(switch_busy), 0);
        check("cancel speed kept", int'(speed_active), 1);
      end
    end
    for (int i = 0; i < 10; i++) step(2'b01, 8'($urandom), 1'b0, 1'b0);

    // 10M.
    settle(2'b00, 300, "switch to 10M");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(2'b00, 8'($urandom), 1'b0, 1'b0);
      cnt += int'(gmii_bus.tx_clk_en);
    end
    check("10M clk_en per 100 cycles", cnt, 2);

    // Reset asserted during the guard gap at 10M.
    for (int i = 0; i < 200; i++) begin
      if (m_mode == M_GUARD) break;
      step(2'b10, 8'($urandom), 1'b0, 1'b0);
    end
    step(2'b10, 8'h00, 1'b0, 1'b0);
    step(2'b10, 8'h00, 1'b0, 1'b0);
    check("guard txc quiet", int'({txc_d1, txc_d2}), 0);
    check("guard clk_en low", int'(gmii_bus.tx_clk_en), 0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async reset txc", int'({txc_d1, txc_d2}), 'b10);
    check("async reset txd", int'({txd_d1, txd_d2}), 0);
    check("async reset clk_en", int'(gmii_bus.tx_clk_en), 1);
    check("async reset speed", int'(speed_active), 2);
    check("async reset busy", int'(switch_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(2'b10, 8'($urandom), 1'b1, 1'b0);
    check("post-reset clk_en", int'(gmii_bus.tx_clk_en), 1);

    // Randomised traffic with occasional speed requests.
    frame_left = 0;
    sreq = 2'b10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) sreq = 2'($urandom);
      e = (frame_left > 0);
      step(sreq, 8'($urandom), e, (e && $urandom_range(0, 15) == 0) || (!e && $urandom_range(0, 31) == 0));
      if (m_last_cen) begin
        if (frame_left > 0) frame_left--;
        else if ($urandom_range(0, 5) == 0) frame_left = $urandom_range(1, 12);
      end
    end
    for (int i = 0; i < 3; i++) step(sreq, 8'h00, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("scoreboard drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
